// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// and the mux-select / ALU-op codes driven onto the datapath.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RWB    = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_SH    = 6'h29;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    localparam logic [1:0] SRCB_B      = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMMSH2 = 2'd3;

    localparam logic [1:0] PCSRC_ALU    = 2'd0;
    localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
    localparam logic [1:0] PCSRC_JUMP   = 2'd2;

    // Loads and stores share MEMADR; this picks the branch out of it.
    function automatic logic is_load(input logic [5:0] op);
        return (op == OP_LW) || (op == OP_LH);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bundle between the FSM (master) and the datapath/memory (slave).
interface mips_multicycle_control_if;
    logic [5:0] Instruction;
    logic       mem_ready;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       Half;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSource;
    logic [3:0] state;
    logic       instr_done;
    logic       illegal_op;
    logic       mem_err;

    modport master (
        input  Instruction, mem_ready,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, Half, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               state, instr_done, illegal_op, mem_err
    );

    modport slave (
        output Instruction, mem_ready,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, Half, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               state, instr_done, illegal_op, mem_err
    );
endinterface

// File: rtl/mips_mem_wait_timer.sv
// Counts consecutive stalled cycles in a memory-waiting state and flags the
// cycle on which the wait budget runs out.
module mips_mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,       // holding in a wait state with mem_ready low
    output logic timeout
);
    logic [CNT_W-1:0] cnt;

    assign timeout = en && (cnt == CNT_W'(MEM_TIMEOUT - 1));

    // Any non-stall cycle (entry, completion, other states) restarts the count;
    // the timeout cycle itself also restarts it since the FSM re-enters FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                cnt <= '0;
        else if (!en || timeout)   cnt <= '0;
        else                       cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS control FSM: Moore control word per state, with mem_ready
// gating in the memory states and a wait timeout that aborts to FETCH.
module mips_multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    mips_multicycle_control_if.master  bus
);
    state_t     state, state_nxt;
    logic       wait_en, timeout;
    logic       pcw, pcwc, iord, mrd, mwr, half, irw, m2r, rdst, rw, srca;
    logic [1:0] srcb, aluop, pcsrc;
    logic       done, ill, merr;
    logic [5:0] op;

    assign op      = bus.Instruction;
    assign wait_en = ((state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR))
                     && !bus.mem_ready;

    mips_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (wait_en),
        .timeout (timeout)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_FETCH;
        else        state <= state_nxt;
    end

    // Next state and control word; timeout aborts to FETCH with no writes.
    always_comb begin
        state_nxt = state;
        pcw = 1'b0; pcwc = 1'b0; iord = 1'b0; mrd = 1'b0; mwr = 1'b0;
        half = 1'b0; irw = 1'b0; m2r = 1'b0; rdst = 1'b0; rw = 1'b0;
        srca = 1'b0; srcb = SRCB_B; aluop = ALUOP_ADD; pcsrc = PCSRC_ALU;
        done = 1'b0; ill = 1'b0; merr = 1'b0;
        unique case (state)
            S_FETCH: begin
                mrd  = 1'b1;
                srcb = SRCB_FOUR;
                irw  = bus.mem_ready;
                pcw  = bus.mem_ready;
                if (bus.mem_ready) state_nxt = S_DECODE;
                else if (timeout)  merr = 1'b1;
            end
            S_DECODE: begin
                srcb = SRCB_IMMSH2;
                case (op)
                    OP_RTYPE:                    state_nxt = S_EXEC;
                    OP_ADDI:                     state_nxt = S_ADDIEX;
                    OP_BEQ:                      state_nxt = S_BRANCH;
                    OP_J:                        state_nxt = S_JUMP;
                    OP_LW, OP_LH, OP_SW, OP_SH:  state_nxt = S_MEMADR;
                    default: begin
                        ill       = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                srca      = 1'b1;
                srcb      = SRCB_IMM;
                state_nxt = is_load(op) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mrd  = 1'b1;
                iord = 1'b1;
                half = (op == OP_LH);
                if (bus.mem_ready) state_nxt = S_MEMWB;
                else if (timeout) begin
                    merr      = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_MEMWB: begin
                rw = 1'b1; m2r = 1'b1; done = 1'b1;
                state_nxt = S_FETCH;
            end
            S_MEMWR: begin
                mwr  = 1'b1;
                iord = 1'b1;
                half = (op == OP_SH);
                if (bus.mem_ready) begin
                    done      = 1'b1;
                    state_nxt = S_FETCH;
                end else if (timeout) begin
                    merr      = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_EXEC: begin
                srca = 1'b1; srcb = SRCB_B; aluop = ALUOP_FUNCT;
                state_nxt = S_RWB;
            end
            S_RWB: begin
                rw = 1'b1; rdst = 1'b1; done = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ADDIEX: begin
                srca = 1'b1; srcb = SRCB_IMM;
                state_nxt = S_ADDIWB;
            end
            S_ADDIWB: begin
                rw = 1'b1; done = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                srca = 1'b1; srcb = SRCB_B; aluop = ALUOP_SUB;
                pcwc = 1'b1; pcsrc = PCSRC_ALUOUT; done = 1'b1;
                state_nxt = S_FETCH;
            end
            S_JUMP: begin
                pcw = 1'b1; pcsrc = PCSRC_JUMP; done = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Hold every output low while reset is asserted, even though state=FETCH.
    assign bus.PCWrite     = rst_n & pcw;
    assign bus.PCWriteCond = rst_n & pcwc;
    assign bus.IorD        = rst_n & iord;
    assign bus.MemRead     = rst_n & mrd;
    assign bus.MemWrite    = rst_n & mwr;
    assign bus.Half        = rst_n & half;
    assign bus.IRWrite     = rst_n & irw;
    assign bus.MemtoReg    = rst_n & m2r;
    assign bus.RegDst      = rst_n & rdst;
    assign bus.RegWrite    = rst_n & rw;
    assign bus.ALUSrcA     = rst_n & srca;
    assign bus.ALUSrcB     = rst_n ? srcb  : 2'd0;
    assign bus.ALUOp       = rst_n ? aluop : 2'd0;
    assign bus.PCSource    = rst_n ? pcsrc : 2'd0;
    assign bus.state       = rst_n ? 4'(state) : 4'd0;
    assign bus.instr_done  = rst_n & done;
    assign bus.illegal_op  = rst_n & ill;
    assign bus.mem_err     = rst_n & merr;
endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed-vector bench: each cycle drives opcode/mem_ready and compares the
// full packed control word against a hand-written expected word.
module tb_mips_multicycle_control;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   nvec = 0;
    int   nerr = 0;

    mips_multicycle_control_if bus ();

    mips_multicycle_control #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // [23]PCWrite [22]PCWriteCond [21]IorD [20]MemRead [19]MemWrite [18]Half
    // [17]IRWrite [16]MemtoReg [15]RegDst [14]RegWrite [13]ALUSrcA
    // [12:11]ALUSrcB [10:9]ALUOp [8:7]PCSource [6:3]state [2]done [1]ill [0]err
    logic [23:0] obs;
    assign obs = {bus.PCWrite, bus.PCWriteCond, bus.IorD, bus.MemRead,
                  bus.MemWrite, bus.Half, bus.IRWrite, bus.MemtoReg,
                  bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB,
                  bus.ALUOp, bus.PCSource, bus.state, bus.instr_done,
                  bus.illegal_op, bus.mem_err};

    function automatic logic [23:0] cw(
        input int pcw, pcwc, iord, mrd, mwr, half, irw, m2r, rdst, rw, srca,
        input int srcb, aluop, pcsrc, st, done, ill, merr);
        return {pcw[0], pcwc[0], iord[0], mrd[0], mwr[0], half[0], irw[0],
                m2r[0], rdst[0], rw[0], srca[0], srcb[1:0], aluop[1:0],
                pcsrc[1:0], st[3:0], done[0], ill[0], merr[0]};
    endfunction

    task automatic chk(input string tag, input logic [23:0] got, input logic [23:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    // Called aligned to a negedge: drive, settle, compare, advance one cycle.
    task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                       input logic [23:0] exp);
        bus.Instruction = op;
        bus.mem_ready   = rdy;
        #1;
        chk(tag, obs, exp);
        @(negedge clk);
    endtask

    logic [23:0] W_FETCH, W_FWAIT, W_DEC, W_DECILL, W_EXEC, W_RWB, W_MADR;
    logic [23:0] W_MRD, W_MRDH, W_MWB, W_MWR, W_MWRH, W_MWRW, W_BR, W_J;
    logic [23:0] W_AEX, W_AWB;

    initial begin
        //           pcw wc io mr mw h ir m2 rd rw sa sb op ps st dn il er
        W_FETCH  = cw(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        W_FWAIT  = cw(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        W_DEC    = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 0, 0);
        W_DECILL = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 1, 0, 1, 0);
        W_EXEC   = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 6, 0, 0, 0);
        W_RWB    = cw(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        W_MADR   = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 2, 0, 0, 0);
        W_MRD    = cw(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        W_MRDH   = cw(0, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0);
        W_MWB    = cw(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 4, 1, 0, 0);
        W_MWR    = cw(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
        W_MWRH   = cw(0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5, 1, 0, 0);
        W_MWRW   = cw(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5, 0, 0, 0);
        W_BR     = cw(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 8, 1, 0, 0);
        W_J      = cw(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 11, 1, 0, 0);
        W_AEX    = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 9, 0, 0, 0);
        W_AWB    = cw(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 10, 1, 0, 0);

        bus.Instruction = 6'h00;
        bus.mem_ready   = 1'b1;
        @(negedge clk);
        // Reset held: all outputs low even with mem_ready high.
        cyc("rst_hold0", 6'h00, 1'b1, 24'h0);
        cyc("rst_hold1", 6'h23, 1'b1, 24'h0);
        rst_n = 1'b1;

        // R-type
        cyc("r_fetch",  6'h00, 1'b1, W_FETCH);
        cyc("r_decode", 6'h00, 1'b1, W_DEC);
        cyc("r_exec",   6'h00, 1'b1, W_EXEC);
        cyc("r_rwb",    6'h00, 1'b1, W_RWB);

        // lw with 3 stall cycles in MEMRD
        cyc("lw_fetch",  6'h23, 1'b1, W_FETCH);
        cyc("lw_decode", 6'h23, 1'b1, W_DEC);
        cyc("lw_memadr", 6'h23, 1'b1, W_MADR);
        for (int i = 0; i < 3; i++) cyc("lw_memrd_wait", 6'h23, 1'b0, W_MRD);
        cyc("lw_memrd",  6'h23, 1'b1, W_MRD);
        cyc("lw_memwb",  6'h23, 1'b1, W_MWB);

        // sh
        cyc("sh_fetch",  6'h29, 1'b1, W_FETCH);
        cyc("sh_decode", 6'h29, 1'b1, W_DEC);
        cyc("sh_memadr", 6'h29, 1'b1, W_MADR);
        cyc("sh_memwr",  6'h29, 1'b1, W_MWRH);

        // sw (full word)
        cyc("sw_fetch",  6'h2B, 1'b1, W_FETCH);
        cyc("sw_decode", 6'h2B, 1'b1, W_DEC);
        cyc("sw_memadr", 6'h2B, 1'b1, W_MADR);
        cyc("sw_memwr",  6'h2B, 1'b1, W_MWR);

        // lh
        cyc("lh_fetch",  6'h21, 1'b1, W_FETCH);
        cyc("lh_decode", 6'h21, 1'b1, W_DEC);
        cyc("lh_memadr", 6'h21, 1'b1, W_MADR);
        cyc("lh_memrd",  6'h21, 1'b1, W_MRDH);
        cyc("lh_memwb",  6'h21, 1'b1, W_MWB);

        // beq, j, addi
        cyc("beq_fetch",  6'h04, 1'b1, W_FETCH);
        cyc("beq_decode", 6'h04, 1'b1, W_DEC);
        cyc("beq_branch", 6'h04, 1'b1, W_BR);
        cyc("j_fetch",    6'h02, 1'b1, W_FETCH);
        cyc("j_decode",   6'h02, 1'b1, W_DEC);
        cyc("j_jump",     6'h02, 1'b1, W_J);
        cyc("addi_fetch", 6'h08, 1'b1, W_FETCH);
        cyc("addi_dec",   6'h08, 1'b1, W_DEC);
        cyc("addi_ex",    6'h08, 1'b1, W_AEX);
        cyc("addi_wb",    6'h08, 1'b1, W_AWB);

        // illegal opcode
        cyc("ill_fetch",  6'h3F, 1'b1, W_FETCH);
        cyc("ill_decode", 6'h3F, 1'b1, W_DECILL);

        // FETCH stuck: timeout on the 16th stalled cycle
        for (int i = 1; i <= 15; i++) cyc("fto_wait", 6'h00, 1'b0, W_FWAIT);
        cyc("fto_err",   6'h00, 1'b0, W_FWAIT | 24'h1);
        cyc("fto_after", 6'h00, 1'b0, W_FWAIT);

        // MEMRD: mem_ready arrives exactly on the would-be timeout cycle
        cyc("lwb_fetch",  6'h23, 1'b1, W_FETCH);
        cyc("lwb_decode", 6'h23, 1'b1, W_DEC);
        cyc("lwb_memadr", 6'h23, 1'b1, W_MADR);
        for (int i = 1; i <= 15; i++) cyc("lwb_wait", 6'h23, 1'b0, W_MRD);
        cyc("lwb_memrd",  6'h23, 1'b1, W_MRD);
        cyc("lwb_memwb",  6'h23, 1'b1, W_MWB);

        // MEMWR timeout
        cyc("swt_fetch",  6'h2B, 1'b1, W_FETCH);
        cyc("swt_decode", 6'h2B, 1'b1, W_DEC);
        cyc("swt_memadr", 6'h2B, 1'b1, W_MADR);
        for (int i = 1; i <= 15; i++) cyc("swt_wait", 6'h2B, 1'b0, W_MWRW);
        cyc("swt_err",    6'h2B, 1'b0, W_MWRW | 24'h1);
        cyc("swt_refetch", 6'h2B, 1'b1, W_FETCH);

        // Async reset in the middle of MEMWR
        cyc("rm_decode", 6'h2B, 1'b1, W_DEC);
        cyc("rm_memadr", 6'h2B, 1'b1, W_MADR);
        cyc("rm_memwr",  6'h2B, 1'b0, W_MWRW);
        rst_n = 1'b0;
        #1;
        chk("rm_reset", obs, 24'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc("rm_fetch",  6'h00, 1'b1, W_FETCH);
        cyc("rm_decode2", 6'h00, 1'b1, W_DEC);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Multicycle MIPS control FSM. Sequences a shared-memory datapath (PC, IR, A/B, ALUOut, MDR) through fetch, decode, execute, memory and writeback.
- Replaces per-instruction combinational control when one memory port and one ALU are time-shared across cycles.
- Adds a memory ready handshake with a timeout, halfword access, and illegal-opcode detection.

Parameters:
- MEM_TIMEOUT, 16, max cycles to wait for mem_ready in a memory state before abort (≥2)
- CNT_W, 5, width of wait counter; must hold MEM_TIMEOUT

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- Instruction  in  6  opcode IR[31:26], valid from DECODE onward
- mem_ready  in  1  memory completes current access this cycle
- PCWrite  out  1  unconditional PC load
- PCWriteCond  out  1  PC load if ALU zero
- IorD  out  1  memory address: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- Half  out  1  memory access is halfword (lh/sh)
- IRWrite  out  1  IR load
- MemtoReg  out  1  writeback source: 0=ALUOut, 1=MDR
- RegDst  out  1  dest reg: 0=rt, 1=rd
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0=PC, 1=A
- ALUSrcB  out  2  0=B, 1=const 4, 2=signext imm, 3=signext imm<<2
- ALUOp  out  2  0=add, 1=sub, 2=funct-decoded
- PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target
- state  out  4  current state, debug
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
- mem_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- States (encoding is package constants): FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Outputs are Moore, decoded from state only, except the mem_ready gating below. Unlisted outputs are 0.
- Reset (rst_n low, async): state=FETCH, wait counter=0, and every output is forced to 0 for as long as rst_n stays low. Applies mid-instruction with no partial writes. First fetch happens on the first edge after release.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=1, ALUOp=0, PCSource=0. IRWrite and PCWrite =mem_ready. If mem_ready, go to DECODE; else stay.
- DECODE: ALUSrcA=0, ALUSrcB=3, ALUOp=0. Next state by opcode:
  - 0x00 -> EXEC
  - 0x08 -> ADDIEX
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x23, 0x21, 0x2B, 0x29 -> MEMADR
  - any other opcode: illegal_op=1, go to FETCH. instr_done stays 0 on this path.
- MEMADR: ALUSrcA=1, ALUSrcB=2, ALUOp=0. Loads go to MEMRD, stores to MEMWR.
- MEMRD: MemRead=1, IorD=1, Half=(op==0x21). If mem_ready go to MEMWB, else stay.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1, go to FETCH.
- MEMWR: MemWrite=1, IorD=1, Half=(op==0x29). If mem_ready, instr_done=1 and go to FETCH; else stay.
- EXEC: ALUSrcA=1, ALUSrcB=0, ALUOp=2, go to RWB.
- RWB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1, go to FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=2, ALUOp=0, go to ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, instr_done=1, go to FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=0, ALUOp=1, PCWriteCond=1, PCSource=1, instr_done=1, go to FETCH.
- JUMP: PCWrite=1, PCSource=2, instr_done=1, go to FETCH.
- Wait counter:
  - Cleared on entry to FETCH, MEMRD and MEMWR, and whenever mem_ready=1.
  - Increments each cycle one of those states holds with mem_ready=0.
  - On the cycle the count reaches MEM_TIMEOUT-1 with mem_ready still 0: mem_err=1, no PC, IR or register write, go to FETCH.
  - From FETCH this re-fetches the same PC. From MEMWR, MemWrite drops.
  - mem_ready=1 on that same cycle wins: normal completion, no mem_err.
- Opcode is sampled combinationally from Instruction. IR is stable after FETCH, so no opcode latch is needed.
- Cycle counts with mem_ready=1 every cycle: R-type 4, addi 4, lw/lh 5, sw/sh 4, beq 3, j 3.

Decomposition:
- Package mips_ctrl_pkg: state constants, opcode constants (OP_RTYPE, OP_ADDI, OP_BEQ, OP_J, OP_LW, OP_LH, OP_SW, OP_SH), ALUOp, ALUSrcB and PCSource encodings.
- One sub-module, mips_mem_wait_timer: counter, clear/enable, timeout flag. All else lives in one FSM module.

Test Plan:
- R-type 0x00, mem_ready=1 -> states 0,1,6,7. In state 7: RegWrite=1, RegDst=1, instr_done=1. Then FETCH.
- lw 0x23 with mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles with MemRead=1, IorD=1. Then MEMWB: RegWrite=1, MemtoReg=1. Total 8 cycles.
- sh 0x29, mem_ready=1 -> MEMWR shows MemWrite=1, Half=1. instr_done pulses there; back to FETCH.
- beq 0x04 then j 0x02 -> BRANCH: PCWriteCond=1, ALUOp=1, PCSource=1. JUMP: PCWrite=1, PCSource=2. 3 cycles each.
- Opcode 0x3F -> illegal_op one pulse in DECODE, no RegWrite/MemWrite, next state FETCH.
- mem_ready stuck 0 in FETCH with MEM_TIMEOUT=16 -> mem_err pulses at the 16th FETCH cycle, PCWrite/IRWrite never 1. Also: rst_n low during MEMWR -> all outputs 0 immediately, state=FETCH.
